operand_issue: RTL and testbench
================================

Name: operand_issue

Overview:
- Issue stage directly upstream of the combinational ALU.
- Holds the 32x32 architectural register file and reads two source operands per instruction.
- Blocks read-after-write and write-after-write hazards with a per-register pending scoreboard.
- Presents a registered {op, rd1, rd2, shift_amt, dest} bundle to the ALU under a valid/ready handshake. Results return through a write-back port.

Parameters:
- NREGS, 32, number of architectural registers (power of two; address width = log2(NREGS)).
- XLEN, 32, data width; must match the ALU operand width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream holds a decoded instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_op  input  4  ALU opcode, passed through unmodified (0..8 defined; others passed through, ALU yields 0).
- in_rs1  input  5  source register 1 address.
- in_rs2  input  5  source register 2 address.
- in_rd  input  5  destination register address; 0 = no write-back expected.
- in_shamt  input  5  shift amount, passed through.
- out_valid  output  1  bundle on out_* is valid.
- out_ready  input  1  downstream (ALU/execute register) consumes the bundle.
- out_op  output  4  registered opcode.
- out_rd1  output  XLEN  registered operand 1.
- out_rd2  output  XLEN  registered operand 2.
- out_shamt  output  5  registered shift amount.
- out_dest  output  5  registered destination tag.
- wb_en  input  1  write-back strobe.
- wb_addr  input  5  write-back register address.
- wb_data  input  XLEN  write-back data.

Behaviour:
- Reset (async, rst_n=0): all registers and all pending bits clear to 0; out_valid=0; out_op, out_rd1, out_rd2, out_shamt and out_dest = 0. in_ready is combinational and may rise once reset is released.
- Register 0 is hardwired to 0: reads return 0, writes are ignored, and it is never marked pending.
- Write-back: on wb_en with wb_addr!=0, reg[wb_addr] <= wb_data at the clock edge and pending[wb_addr] clears.
- Bypass: a read of address A in the same cycle as a write-back with wb_en=1 and wb_addr=A returns wb_data, not the stale value.
- Hazard (combinational): true when in_valid and any of the following holds:
  - rs1!=0 and pending[rs1] and not (wb_en and wb_addr==rs1);
  - the same condition for rs2;
  - rd!=0 and pending[rd] and not (wb_en and wb_addr==rd).
- Output slot free = !out_valid || out_ready.
- in_ready = slot free && !hazard. in_ready may depend on in_rs1, in_rs2 and in_rd; upstream must hold its fields stable while in_valid=1.
- Issue (in_valid && in_ready):
  - out_* load the operands (with bypass), op, shamt and rd; out_valid <= 1.
  - pending[rd] <= 1 when rd!=0.
  - Latency from acceptance to out_valid is 1 cycle.
- No issue but out_ready && out_valid: out_valid <= 0.
- Back-pressure: while out_valid && !out_ready, out_* hold stable and in_ready=0.
- Simultaneous set and clear: when an issue sets pending[X] and a write-back clears pending[X] in the same cycle, the set wins (final pending[X]=1).
- Throughput: one instruction per cycle when there are no hazards and out_ready=1.
- Reset mid-operation: all in-flight state is discarded, the scoreboard clears, and register contents return to 0.
- Width rule: operands pass bit-exact; no sign extension or arithmetic is performed here.

Decomposition:
- Shared package:
  - ALU opcode constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SLL=4, OP_SRL=5, OP_SRA=6, OP_SGT=7, OP_SLT=8.
  - XLEN and register-address-width constants.
  - The issue-bundle struct typedef.
- Sub-module regfile_2r1w:
  - Array plus write port plus read mux with bypass and r0 forcing.
  - The scoreboard and handshake stay in operand_issue.

Test Plan:
- Reset then write-back: wb r5=0x0000_00A5; issue op=0, rs1=5, rs2=0, rd=6 -> next cycle out_valid=1, out_rd1=0x0000_00A5, out_rd2=0, out_dest=6.
- Same-cycle bypass: wb r7=0xDEAD_BEEF together with issue rs1=7 -> out_rd1=0xDEAD_BEEF.
- RAW stall: issue rd=3, then issue rs2=3 -> in_ready=0 until wb_addr=3 is applied. in_ready rises in the wb cycle, and out_rd2 equals the wb_data.
- WAW and simultaneous events:
  - With r4 pending, an issue with rd=4 stalls.
  - When wb r4 arrives with the issue still asserted, the issue is accepted that cycle and pending[4]=1 afterwards.
- Back-pressure: hold out_ready=0 with out_valid=1 -> out_* stable for 5 cycles and in_ready=0. On release, 3 back-to-back independent issues give out_valid=1 on 3 consecutive cycles.
- r0 and async reset:
  - wb r0=0xFFFF_FFFF is ignored; a read of r0 returns 0; issuing rd=0 leaves nothing pending.
  - Asserting rst_n=0 mid-stall clears out_valid and pending immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_issue_pkg.sv
// Shared definitions for the operand issue stage: opcodes, widths and the
// registered bundle handed to the ALU.
package operand_issue_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SLL = 4'd4,
        OP_SRL = 4'd5,
        OP_SRA = 4'd6,
        OP_SGT = 4'd7,
        OP_SLT = 4'd8
    } alu_op_e;

    // op stays raw so undefined opcodes pass through untouched
    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [4:0]        shamt;
        logic [REG_AW-1:0] dest;
    } issue_bundle_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two read ports with write-back bypass,
// one write port, register 0 hardwired to zero.
module regfile_2r1w
    import operand_issue_pkg::*;
#(
    parameter int unsigned NREGS = NUM_REGS,
    parameter int unsigned XLEN  = DATA_W,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass first, then r0 forcing so a write-back to r0 never leaks through
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        if (we_i && waddr_i == raddr1_i) rdata1_o = wdata_i;
        if (raddr1_i == '0) rdata1_o = '0;

        rdata2_o = regs_q[raddr2_i];
        if (we_i && waddr_i == raddr2_i) rdata2_o = wdata_i;
        if (raddr2_i == '0) rdata2_o = '0;
    end

endmodule

// File: rtl/operand_issue.sv
// Issue stage ahead of the ALU: operand read, pending-register scoreboard
// for RAW/WAW hazards and a registered valid/ready output bundle.
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int unsigned NREGS = NUM_REGS,
    parameter int unsigned XLEN  = DATA_W,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic [4:0]      in_shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_op,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output logic [4:0]      out_shamt,
    output logic [AW-1:0]   out_dest,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    logic [NREGS-1:0] pend_q, pend_d;
    issue_bundle_t    bundle_q, bundle_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  rs1_data, rs2_data;
    logic             busy_rs1, busy_rs2, busy_rd;
    logic             hazard, slot_free, issue;

    regfile_2r1w #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (in_rs1),
        .raddr2_i (in_rs2),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    // A register being written back this cycle is no longer a hazard
    assign busy_rs1  = (in_rs1 != '0) && pend_q[in_rs1] && !(wb_en && wb_addr == in_rs1);
    assign busy_rs2  = (in_rs2 != '0) && pend_q[in_rs2] && !(wb_en && wb_addr == in_rs2);
    assign busy_rd   = (in_rd  != '0) && pend_q[in_rd]  && !(wb_en && wb_addr == in_rd);
    assign hazard    = in_valid && (busy_rs1 || busy_rs2 || busy_rd);
    assign slot_free = !valid_q || out_ready;
    assign in_ready  = slot_free && !hazard;
    assign issue     = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        pend_d   = pend_q;
        if (issue) begin
            valid_d  = 1'b1;
            bundle_d = '{op: in_op, rd1: rs1_data, rd2: rs2_data,
                         shamt: in_shamt, dest: in_rd};
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        // Clear before set: an issue claiming the register being retired keeps it pending
        if (wb_en) pend_d[wb_addr] = 1'b0;
        if (issue) pend_d[in_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            pend_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            pend_q   <= pend_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op    = bundle_q.op;
    assign out_rd1   = bundle_q.rd1;
    assign out_rd2   = bundle_q.rd2;
    assign out_shamt = bundle_q.shamt;
    assign out_dest  = bundle_q.dest;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed vector table, hand-written corner
// sequences and constrained-random traffic checked against a reference model.
module tb_operand_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, wb_en;
    logic [3:0]  in_op, out_op;
    logic [4:0]  in_rs1, in_rs2, in_rd, in_shamt, out_shamt, out_dest, wb_addr;
    logic [31:0] out_rd1, out_rd2, wb_data;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    operand_issue #(.NREGS(32), .XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_rd1   (out_rd1),
        .out_rd2   (out_rd2),
        .out_shamt (out_shamt),
        .out_dest  (out_dest),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state as plain arrays
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_ov;
    logic [3:0]  m_op;
    logic [31:0] m_rd1, m_rd2;
    logic [4:0]  m_sh, m_dest;
    bit          last_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_ov = 1'b0; m_op = '0; m_rd1 = '0; m_rd2 = '0; m_sh = '0; m_dest = '0;
        last_acc = 1'b0;
    endtask

    function automatic logic [31:0] mdl_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit mdl_blocked(input logic [4:0] a);
        return (a != 0) && m_pend[a] && !(wb_en && wb_addr == a);
    endfunction

    function automatic bit mdl_ready();
        bit haz;
        haz = in_valid && (mdl_blocked(in_rs1) || mdl_blocked(in_rs2) || mdl_blocked(in_rd));
        return (!m_ov || out_ready) && !haz;
    endfunction

    task automatic mdl_step(input bit rdy);
        logic [31:0] v1, v2;
        v1 = mdl_read(in_rs1);
        v2 = mdl_read(in_rs2);
        last_acc = in_valid && rdy;
        if (last_acc) begin
            m_ov = 1'b1; m_op = in_op; m_rd1 = v1; m_rd2 = v2; m_sh = in_shamt; m_dest = in_rd;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (wb_en && wb_addr != 0) begin
            m_regs[wb_addr] = wb_data;
            m_pend[wb_addr] = 1'b0;
        end
        if (last_acc && in_rd != 0) m_pend[in_rd] = 1'b1;
    endtask

    // One clock: in_ready sampled at the falling edge, outputs 1ns after the rising edge
    task automatic cycle(output logic rdy_seen);
        bit exp_rdy;
        @(negedge clk);
        rdy_seen = in_ready;
        exp_rdy  = mdl_ready();
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        mdl_step(exp_rdy);
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_op",    32'(out_op),    32'(m_op));
        check("out_rd1",   out_rd1,        m_rd1);
        check("out_rd2",   out_rd2,        m_rd2);
        check("out_shamt", 32'(out_shamt), 32'(m_sh));
        check("out_dest",  32'(out_dest),  32'(m_dest));
    endtask

    function automatic logic [4:0] pick_wb();
        int unsigned s;
        s = $urandom_range(0, 31);
        for (int unsigned k = 0; k < 32; k++) begin
            if (m_pend[(s + k) % 32]) return 5'((s + k) % 32);
        end
        return 5'($urandom_range(0, 15));
    endfunction

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd, sh;
        logic        ordy, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e_rdy, e_ov;
        logic [31:0] e_rd1, e_rd2;
        logic [4:0]  e_dest;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic r;

        tbl[0]  = '{1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 32'h0000_00A5, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0};
        tbl[1]  = '{1'b1, 4'd0, 5'd5, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h0000_00A5, 32'h0, 5'd6};
        tbl[2]  = '{1'b1, 4'd1, 5'd7, 5'd5, 5'd8, 5'd0, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_00A5, 5'd8};
        tbl[3]  = '{1'b1, 4'd5, 5'd0, 5'd6, 5'd9, 5'd4, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_00A5, 5'd8};
        tbl[4]  = '{1'b1, 4'd5, 5'd0, 5'd6, 5'd9, 5'd4, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_00A5, 5'd8};
        tbl[5]  = '{1'b1, 4'd5, 5'd0, 5'd6, 5'd9, 5'd4, 1'b1, 1'b1, 5'd6, 32'h1234_5678, 1'b1, 1'b1, 32'h0, 32'h1234_5678, 5'd9};
        tbl[6]  = '{1'b1, 4'd3, 5'd0, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 5'd9};
        tbl[7]  = '{1'b1, 4'd3, 5'd0, 5'd0, 5'd8, 5'd0, 1'b1, 1'b1, 5'd8, 32'h0000_0088, 1'b1, 1'b1, 32'h0, 32'h0, 5'd8};
        tbl[8]  = '{1'b1, 4'd2, 5'd8, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd8};
        tbl[9]  = '{1'b1, 4'd2, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 32'h0, 5'd0};
        tbl[10] = '{1'b1, 4'd4, 5'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd0};

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_shamt = '0; out_ready = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        mdl_reset();
        #3;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_rd1", out_rd1, 32'h0);
        check("rst_out_dest", 32'(out_dest), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].v; in_op = tbl[i].op; in_rs1 = tbl[i].rs1; in_rs2 = tbl[i].rs2;
            in_rd = tbl[i].rd; in_shamt = tbl[i].sh; out_ready = tbl[i].ordy;
            wb_en = tbl[i].we; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
            cycle(r);
            check($sformatf("vec%0d_in_ready", i), 32'(r), 32'(tbl[i].e_rdy));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d_out_rd1", i), out_rd1, tbl[i].e_rd1);
            check($sformatf("vec%0d_out_rd2", i), out_rd2, tbl[i].e_rd2);
            check($sformatf("vec%0d_out_dest", i), 32'(out_dest), 32'(tbl[i].e_dest));
        end

        // Back-pressure: fill the slot, stall it for 5 cycles, then stream 3 issues
        in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
        cycle(r);
        in_valid = 1'b1; in_op = 4'd7; in_rs1 = 5'd5; in_rs2 = 5'd7; in_rd = 5'd10; in_shamt = 5'd2;
        out_ready = 1'b0;
        cycle(r);
        check("bp_fill_ready", 32'(r), 32'h1);
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd11; in_op = 4'd0;
        for (int i = 0; i < 5; i++) begin
            cycle(r);
            check("bp_in_ready", 32'(r), 32'h0);
            check("bp_out_valid", 32'(out_valid), 32'h1);
            check("bp_out_rd1", out_rd1, 32'h0000_00A5);
            check("bp_out_rd2", out_rd2, 32'hDEAD_BEEF);
            check("bp_out_dest", 32'(out_dest), 32'd10);
            check("bp_out_op", 32'(out_op), 32'd7);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_rd = 5'(11 + i);
            cycle(r);
            check("b2b_in_ready", 32'(r), 32'h1);
            check("b2b_out_valid", 32'(out_valid), 32'h1);
            check("b2b_out_dest", 32'(out_dest), 32'(11 + i));
        end
        in_valid = 1'b0;
        cycle(r);
        check("drain_out_valid", 32'(out_valid), 32'h0);

        // Asynchronous reset in the middle of a RAW stall
        in_valid = 1'b1; in_op = 4'd6; in_rs1 = 5'd5; in_rs2 = 5'd7; in_rd = 5'd13; out_ready = 1'b0;
        cycle(r);
        in_rs1 = 5'd13; in_rs2 = 5'd0; in_rd = 5'd0;
        cycle(r);
        check("stall_in_ready", 32'(r), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_out_rd1", out_rd1, 32'h0);
        check("arst_out_dest", 32'(out_dest), 32'h0);
        check("arst_out_op", 32'(out_op), 32'h0);
        check("arst_pending_clear", 32'(in_ready), 32'h1);
        mdl_reset();
        #1 rst_n = 1'b1;
        cycle(r);
        check("post_rst_accept", 32'(r), 32'h1);
        in_rs1 = 5'd5; out_ready = 1'b1;
        cycle(r);
        check("post_rst_r5_zero", out_rd1, 32'h0);

        // Random traffic; instruction fields held until accepted
        in_valid = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op    = 4'($urandom_range(0, 15));
                in_rs1   = 5'($urandom_range(0, 15));
                in_rs2   = 5'($urandom_range(0, 15));
                in_rd    = 5'($urandom_range(0, 15));
                in_shamt = 5'($urandom_range(0, 31));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = ($urandom_range(0, 2) == 0);
            wb_addr   = ($urandom_range(0, 1) == 0) ? pick_wb() : 5'($urandom_range(0, 15));
            wb_data   = $urandom();
            cycle(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
